brick_health_tracker: RTL and testbench

Parametrised game-status tracker for the brick-breaker datapath, sitting between the collision/erase logic and the top-level game FSM. It loads the level's total brick health on start, subtracts a variable damage per hit with saturation, tracks remaining lives on ball loss, and raises sticky win or lose flags. Win is flagged on the hit that empties health; no extra write is needed.

---
 rtl/brick_health_tracker_if.sv | 32 +++
 rtl/brick_health_tracker.sv | 59 +++++
 tb/tb_brick_health_tracker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/brick_health_tracker_if.sv
// brick_health_tracker_if: level-control, hit/ball-loss inputs and game-status outputs of the tracker.
// The score signal exists only when BHT_SCORE_EN is defined.
interface brick_health_tracker_if #(
    parameter int HEALTH_W = 10,
    parameter int DMG_W    = 2,
    parameter int LIVES    = 3,
    parameter int SCORE_W  = 16
);
    localparam int LIFE_W = $clog2(LIVES + 1);
    logic                start;
    logic [HEALTH_W-1:0] total_health;
    logic                hit_valid;
    logic [DMG_W-1:0]    hit_damage;
    logic                ball_lost;
    logic [HEALTH_W-1:0] health_left;
    logic [LIFE_W-1:0]   lives_left;
    logic                playing;
    logic                win_occurred;
    logic                lose_occurred;
`ifdef BHT_SCORE_EN
    logic [SCORE_W-1:0]  score;
    modport master (output start, total_health, hit_valid, hit_damage, ball_lost,
                    input health_left, lives_left, playing, win_occurred, lose_occurred, score);
    modport slave  (input start, total_health, hit_valid, hit_damage, ball_lost,
                    output health_left, lives_left, playing, win_occurred, lose_occurred, score);
`else
    modport master (output start, total_health, hit_valid, hit_damage, ball_lost,
                    input health_left, lives_left, playing, win_occurred, lose_occurred);
    modport slave  (input start, total_health, hit_valid, hit_damage, ball_lost,
                    output health_left, lives_left, playing, win_occurred, lose_occurred);
`endif
endinterface

// File: rtl/brick_health_tracker.sv
// brick_health_tracker: level health / lives tracker with sticky win and lose flags.
// Optional BHT_SCORE_EN adds a score of damage actually removed.
module brick_health_tracker #(
    parameter int HEALTH_W = 10,
    parameter int DMG_W    = 2,
    parameter int LIVES    = 3,
    parameter int SCORE_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    brick_health_tracker_if.slave bus
);
    localparam int LIFE_W = $clog2(LIVES + 1);
    // One-hot so each status flag is a single register bit.
    typedef enum logic [3:0] {IDLE = 4'b0001, PLAY = 4'b0010, WIN = 4'b0100, LOSE = 4'b1000} state_t;
    state_t              state;
    logic [HEALTH_W:0]   diff;
    logic [HEALTH_W-1:0] health_next;
    logic [LIFE_W-1:0]   lives_next;
    logic                won;
    logic                lost;
    always_comb begin
        diff        = {1'b0, bus.health_left} - (HEALTH_W+1)'(bus.hit_damage);
        health_next = diff[HEALTH_W] ? '0 : diff[HEALTH_W-1:0];
        lives_next  = bus.lives_left - LIFE_W'(1);
        won         = bus.hit_valid && health_next == '0;
        lost        = bus.ball_lost && lives_next == '0;
    end
    assign bus.playing       = state[1];
    assign bus.win_occurred  = state[2];
    assign bus.lose_occurred = state[3];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bus.health_left <= '0;
            bus.lives_left  <= '0;
        end else if (bus.start) begin
            state           <= bus.total_health == '0 ? WIN : PLAY;
            bus.health_left <= bus.total_health;
            bus.lives_left  <= LIFE_W'(LIVES);
        end else if (state == PLAY) begin
            if (bus.hit_valid) bus.health_left <= health_next;
            if (bus.ball_lost) bus.lives_left <= lives_next;
            state <= won ? WIN : lost ? LOSE : PLAY;
        end
    end
`ifdef BHT_SCORE_EN
    logic [HEALTH_W-1:0] removed;
    assign removed = bus.health_left - health_next;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.score <= '0;
        else if (bus.start)
            bus.score <= '0;
        else if (state == PLAY && bus.hit_valid)
            bus.score <= bus.score + SCORE_W'(removed);
    end
`endif
endmodule

// File: tb/tb_brick_health_tracker.sv
// tb_brick_health_tracker: table-driven directed vectors plus async-reset and score sequences.
module tb_brick_health_tracker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int asserts = 0;
    int fails = 0;
    always #5 clk = ~clk;
    brick_health_tracker_if #(.HEALTH_W(10), .DMG_W(2), .LIVES(3), .SCORE_W(16)) bus ();
    brick_health_tracker #(.HEALTH_W(10), .DMG_W(2), .LIVES(3), .SCORE_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    typedef struct {
        logic       start;
        logic [9:0] total;
        logic       hit;
        logic [1:0] dmg;
        logic       lost;
        logic [9:0] e_health;
        logic [1:0] e_lives;
        logic       e_play;
        logic       e_win;
        logic       e_lose;
        logic [15:0] e_score;
    } vec_t;
    vec_t v[22];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] status();
        return {37'd0, bus.health_left, bus.lives_left, bus.playing, bus.win_occurred, bus.lose_occurred};
    endfunction
    task automatic drive(input logic s, input logic [9:0] t, input logic h, input logic [1:0] d, input logic l);
        bus.start = s;
        bus.total_health = t;
        bus.hit_valid = h;
        bus.hit_damage = d;
        bus.ball_lost = l;
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        //        start total hit dmg lost  health lives play win lose score
        v[0]  = '{1, 10'd5,    0, 0, 0, 10'd5,    2'd3, 1, 0, 0, 16'd0};
        v[1]  = '{0, 10'd0,    1, 2, 0, 10'd3,    2'd3, 1, 0, 0, 16'd2};
        v[2]  = '{0, 10'd0,    1, 2, 0, 10'd1,    2'd3, 1, 0, 0, 16'd4};
        v[3]  = '{0, 10'd0,    1, 3, 0, 10'd0,    2'd3, 0, 1, 0, 16'd5};
        v[4]  = '{0, 10'd0,    1, 1, 0, 10'd0,    2'd3, 0, 1, 0, 16'd5};
        v[5]  = '{0, 10'd0,    0, 0, 1, 10'd0,    2'd3, 0, 1, 0, 16'd5};
        v[6]  = '{1, 10'd0,    1, 1, 1, 10'd0,    2'd3, 0, 1, 0, 16'd0};
        v[7]  = '{1, 10'd7,    1, 3, 1, 10'd7,    2'd3, 1, 0, 0, 16'd0};
        v[8]  = '{0, 10'd0,    0, 0, 1, 10'd7,    2'd2, 1, 0, 0, 16'd0};
        v[9]  = '{0, 10'd0,    0, 0, 1, 10'd7,    2'd1, 1, 0, 0, 16'd0};
        v[10] = '{0, 10'd0,    1, 0, 0, 10'd7,    2'd1, 1, 0, 0, 16'd0};
        v[11] = '{0, 10'd0,    0, 0, 1, 10'd7,    2'd0, 0, 0, 1, 16'd0};
        v[12] = '{0, 10'd0,    1, 3, 1, 10'd7,    2'd0, 0, 0, 1, 16'd0};
        v[13] = '{1, 10'd1,    0, 0, 0, 10'd1,    2'd3, 1, 0, 0, 16'd0};
        v[14] = '{0, 10'd0,    0, 0, 1, 10'd1,    2'd2, 1, 0, 0, 16'd0};
        v[15] = '{0, 10'd0,    0, 0, 1, 10'd1,    2'd1, 1, 0, 0, 16'd0};
        v[16] = '{0, 10'd0,    1, 1, 1, 10'd0,    2'd0, 0, 1, 0, 16'd1};
        v[17] = '{1, 10'd1023, 0, 0, 0, 10'd1023, 2'd3, 1, 0, 0, 16'd0};
        v[18] = '{0, 10'd0,    1, 3, 0, 10'd1020, 2'd3, 1, 0, 0, 16'd3};
        v[19] = '{1, 10'd2,    0, 0, 0, 10'd2,    2'd3, 1, 0, 0, 16'd0};
        v[20] = '{0, 10'd0,    1, 3, 0, 10'd0,    2'd3, 0, 1, 0, 16'd2};
        v[21] = '{0, 10'd0,    0, 0, 0, 10'd0,    2'd3, 0, 1, 0, 16'd2};
        drive(0, 10'd0, 0, 2'd0, 0);
        step();
        step();
        check("reset_state", status(), 64'd0);
        reset = 1'b0;
        drive(0, 10'd9, 1, 2'd1, 1);
        step();
        check("idle_ignores_inputs", status(), 64'd0);
        for (int i = 0; i < 22; i++) begin
            drive(v[i].start, v[i].total, v[i].hit, v[i].dmg, v[i].lost);
            step();
            check($sformatf("vec%0d", i), status(),
                  {37'd0, v[i].e_health, v[i].e_lives, v[i].e_play, v[i].e_win, v[i].e_lose});
`ifdef BHT_SCORE_EN
            check($sformatf("vec%0d_score", i), 64'(bus.score), 64'(v[i].e_score));
`endif
        end
        drive(1, 10'd3, 0, 2'd0, 0);
        step();
        drive(0, 10'd0, 1, 2'd3, 0);
        step();
        check("score_seq_win", status(), {37'd0, 10'd0, 2'd3, 1'b0, 1'b1, 1'b0});
`ifdef BHT_SCORE_EN
        check("score_before_restart", 64'(bus.score), 64'd3);
`endif
        drive(1, 10'd9, 0, 2'd0, 0);
        step();
        drive(0, 10'd0, 1, 2'd2, 0);
        step();
        check("midplay", status(), {37'd0, 10'd7, 2'd3, 1'b1, 1'b0, 1'b0});
`ifdef BHT_SCORE_EN
        check("score_after_restart", 64'(bus.score), 64'd2);
`endif
        drive(0, 10'd0, 0, 2'd0, 0);
        #2 reset = 1'b1;
        #1 check("async_reset_clear", status(), 64'd0);
`ifdef BHT_SCORE_EN
        check("async_reset_score", 64'(bus.score), 64'd0);
`endif
        #1 reset = 1'b0;
        drive(0, 10'd0, 1, 2'd1, 1);
        step();
        step();
        check("idle_after_reset", status(), 64'd0);
        drive(1, 10'd4, 0, 2'd0, 0);
        step();
        check("start_after_reset", status(), {37'd0, 10'd4, 2'd3, 1'b1, 1'b0, 1'b0});
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
